// File: rtl/rv32i_decode_stage_pkg.sv
// Shared RV32I decode definitions: instruction type codes, opcode constants,
// the decoded field bundle and the elastic-buffer state encoding.
package rv32i_decode_stage_pkg;

   localparam logic [2:0] R_TYPE = 3'd0;
   localparam logic [2:0] I_TYPE = 3'd1;
   localparam logic [2:0] S_TYPE = 3'd2;
   localparam logic [2:0] L_TYPE = 3'd3;
   localparam logic [2:0] B_TYPE = 3'd4;
   localparam logic [2:0] J_TYPE = 3'd5;
   localparam logic [2:0] U_TYPE = 3'd6;
   localparam logic [2:0] X_TYPE = 3'd7;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

   typedef struct packed {
      logic [2:0]  itype;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        reg_write;
      logic        illegal;
   } dec_t;

   // Value presented on the outputs straight out of reset.
   function automatic dec_t reset_bundle();
      dec_t b;
      b = '0;
      b.itype = X_TYPE;
      return b;
   endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I field decoder. With RV32I_DECODE_TRAP_EN defined an
// unsupported opcode is flagged illegal; otherwise it becomes addi x0,x0,0.
module rv32i_decoder
   import rv32i_decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   function automatic logic [31:0] imm_i(input logic [31:0] ins);
      logic signed [11:0] f;
      f = ins[31:20];
      return 32'(f);
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] ins);
      logic signed [11:0] f;
      f = {ins[31:25], ins[11:7]};
      return 32'(f);
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] ins);
      logic signed [12:0] f;
      f = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      return 32'(f);
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] ins);
      logic signed [20:0] f;
      f = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      return 32'(f);
   endfunction

   always_comb begin
      dec        = '0;
      dec.opcode = instr[6:0];
      dec.funct3 = instr[14:12];
      dec.funct7 = instr[31:25];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.rd     = instr[11:7];
      case (instr[6:0])
         OPC_OP:     dec.itype = R_TYPE;
         OPC_OPIMM:  begin dec.itype = I_TYPE; dec.imm = imm_i(instr); end
         OPC_LOAD:   begin dec.itype = L_TYPE; dec.imm = imm_i(instr); end
         OPC_STORE:  begin dec.itype = S_TYPE; dec.imm = imm_s(instr); end
         OPC_BRANCH: begin dec.itype = B_TYPE; dec.imm = imm_b(instr); end
         OPC_JAL:    begin dec.itype = J_TYPE; dec.imm = imm_j(instr); end
         OPC_JALR:   begin dec.itype = J_TYPE; dec.imm = imm_i(instr); end
         // U immediate stays unshifted; execute applies the <<12.
         OPC_LUI, OPC_AUIPC: begin
            dec.itype = U_TYPE;
            dec.imm   = {12'd0, instr[31:12]};
         end
         default: begin
`ifdef RV32I_DECODE_TRAP_EN
            dec.itype   = X_TYPE;
            dec.illegal = 1'b1;
`else
            dec.itype  = I_TYPE;
            dec.opcode = OPC_OPIMM;
            dec.funct3 = '0;
            dec.funct7 = '0;
            dec.rs1    = '0;
            dec.rs2    = '0;
            dec.rd     = '0;
`endif
         end
      endcase
      case (dec.itype)
         R_TYPE, I_TYPE, L_TYPE, J_TYPE, U_TYPE: dec.reg_write = (dec.rd != 5'd0);
         default:                                dec.reg_write = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational decode into a two-entry elastic buffer.
// Define RV32I_DECODE_TRAP_EN to halt intake after an illegal instruction issues.
module rv32i_decode_stage
   import rv32i_decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      out_type,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_reg_write,
   output logic            out_illegal
);

   buf_state_e      state_q, state_nxt;
   logic            in_ready_q, halt_q, halt_nxt;
   logic            in_fire, out_fire;
   logic            load_main_dec, load_main_skid, load_skid;
   dec_t            dec, main_p0, skid_p0;
   logic [XLEN-1:0] main_pc_p0, skid_pc_p0;

   rv32i_decoder u_decoder (
      .instr (in_instr),
      .dec   (dec)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_nxt      = state_q;
      load_main_dec  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: if (in_fire) begin
            state_nxt     = ONE;
            load_main_dec = 1'b1;
         end
         ONE: begin
            if (in_fire && !out_fire) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (out_fire && !in_fire) begin
               state_nxt = EMPTY;
            end else if (in_fire && out_fire) begin
               load_main_dec = 1'b1;
            end
         end
         TWO: if (out_fire) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
         end
         default: state_nxt = EMPTY;
      endcase
`ifdef RV32I_DECODE_TRAP_EN
      halt_nxt = halt_q | (out_fire & main_p0.illegal);
`else
      halt_nxt = 1'b0;
`endif
      // A redirect outranks everything, including a same-cycle accept.
      if (flush) begin
         state_nxt      = EMPTY;
         halt_nxt       = 1'b0;
         load_main_dec  = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         halt_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= (state_nxt != TWO) && !halt_nxt;
         halt_q     <= halt_nxt;
      end
   end

   // Stage p0: main (head) and skid registers
   always_ff @(posedge clk) begin
      if (rst) begin
         main_p0    <= reset_bundle();
         main_pc_p0 <= '0;
      end else if (load_main_dec) begin
         main_p0    <= dec;
         main_pc_p0 <= in_pc;
      end else if (load_main_skid) begin
         main_p0    <= skid_p0;
         main_pc_p0 <= skid_pc_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_p0    <= dec;
         skid_pc_p0 <= in_pc;
      end
   end

   assign out_type      = main_p0.itype;
   assign out_opcode    = main_p0.opcode;
   assign out_funct3    = main_p0.funct3;
   assign out_funct7    = main_p0.funct7;
   assign out_rs1       = main_p0.rs1;
   assign out_rs2       = main_p0.rs2;
   assign out_rd        = main_p0.rd;
   assign out_imm       = main_p0.imm;
   assign out_pc        = main_pc_p0;
   assign out_reg_write = main_p0.reg_write;
   assign out_illegal   = main_p0.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: arithmetic reference model, directed
// cases followed by randomized traffic with flushes and resets.
module tb_rv32i_decode_stage;
   import rv32i_decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_imm, out_pc;
   logic [2:0]  out_type, out_funct3;
   logic [6:0]  out_opcode, out_funct7;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_reg_write, out_illegal;

   rv32i_decode_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_type(out_type), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_pc(out_pc), .out_reg_write(out_reg_write),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  t;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, pc;
      logic        rw, ill;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        halted = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] pc_ctr = 32'h0000_1004;
   logic [6:0]  opcs[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      int   v;
      e.t = X_TYPE; e.opc = w[6:0]; e.f3 = w[14:12]; e.f7 = w[31:25];
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
      e.imm = 32'd0; e.pc = pc; e.ill = 1'b0;
      case (w[6:0])
         7'b0110011: e.t = R_TYPE;
         7'b0010011: begin e.t = I_TYPE; v = $signed(w) >>> 20; e.imm = v; end
         7'b0000011: begin e.t = L_TYPE; v = $signed(w) >>> 20; e.imm = v; end
         7'b1100111: begin e.t = J_TYPE; v = $signed(w) >>> 20; e.imm = v; end
         7'b0100011: begin
            e.t = S_TYPE; v = $signed(w) >>> 25;
            e.imm = v * 32 + int'(w[11:7]);
         end
         7'b1100011: begin
            e.t = B_TYPE;
            v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            e.imm = v;
         end
         7'b1101111: begin
            e.t = J_TYPE;
            v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                + int'(w[30:21]) * 2;
            e.imm = v;
         end
         7'b0110111, 7'b0010111: begin e.t = U_TYPE; e.imm = w >> 12; end
         default: begin
`ifdef RV32I_DECODE_TRAP_EN
            e.ill = 1'b1;
`else
            e.t = I_TYPE; e.opc = 7'b0010011; e.f3 = 3'd0; e.f7 = 7'd0;
            e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0;
`endif
         end
      endcase
      e.rw = (e.t inside {R_TYPE, I_TYPE, L_TYPE, J_TYPE, U_TYPE}) && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic exp_t dut_bundle();
      exp_t e;
      e.t = out_type; e.opc = out_opcode; e.f3 = out_funct3; e.f7 = out_funct7;
      e.rs1 = out_rs1; e.rs2 = out_rs2; e.rd = out_rd; e.imm = out_imm; e.pc = out_pc;
      e.rw = out_reg_write; e.ill = out_illegal;
      return e;
   endfunction

   function automatic bit same(input exp_t a, input exp_t b);
      return a.t === b.t && a.opc === b.opc && a.f3 === b.f3 && a.f7 === b.f7 &&
             a.rs1 === b.rs1 && a.rs2 === b.rs2 && a.rd === b.rd && a.imm === b.imm &&
             a.pc === b.pc && a.rw === b.rw && a.ill === b.ill;
   endfunction

   task automatic check_bundle(input string name, input exp_t g, input exp_t r);
      checks++;
      if (!same(g, r)) begin
         errors++;
         $display("FAIL %s got t=%0d opc=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h rw=%b ill=%b required t=%0d opc=%h f3=%h f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h rw=%b ill=%b",
                  name, g.t, g.opc, g.f3, g.f7, g.rs1, g.rs2, g.rd, g.imm, g.pc, g.rw, g.ill,
                  r.t, r.opc, r.f3, r.f7, r.rs1, r.rs2, r.rd, r.imm, r.pc, r.rw, r.ill);
      end
   endtask

   // Monitor: occupancy, handshake and ordering against the scoreboard queue.
   initial begin
      exp_t prev, cur, e;
      bit   prev_stall;
      prev_stall = 1'b0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            continue;
         end
         cur = dut_bundle();
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) && !halted});
         if (prev_stall && out_valid) check_bundle("stall_stable", cur, prev);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output got pc=%h required=none", out_pc);
            end else begin
               e = exp_q.pop_front();
               check_bundle("bundle", cur, e);
               if (e.ill) halted = 1'b1;
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev = cur;
      end
   end

   task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic rs, output bit acc);
      in_valid = v; in_instr = ins; in_pc = pc_ctr; out_ready = ordy; flush = fl; rst = rs;
      @(negedge clk); #1;
      acc = 1'b0;
      if (flush || rst) begin
         exp_q.delete();
         halted = 1'b0;
      end else if (in_valid && in_ready) begin
         exp_q.push_back(model(in_instr, in_pc));
         pc_ctr = pc_ctr + 32'd4;
         acc = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          k;
      w = $urandom();
      k = $urandom_range(0, 11);
      if (k < 9) w[6:0] = opcs[k];
      return w;
   endfunction

   initial begin
      bit acc;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_type", {29'd0, out_type}, {29'd0, X_TYPE});
      check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_fields", {5'd0, out_opcode, out_funct3, out_funct7, out_rd, out_reg_write},
            32'd0);
      mon_en = 1'b1;

      step(1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, acc);
      step(1'b1, 32'hFE00_08E3, 1'b1, 1'b0, 1'b0, acc);
      step(1'b1, 32'h1234_52B7, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

      step(1'b1, 32'h0010_8113, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0021_0193, 1'b0, 1'b0, 1'b0, acc);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 32'h0031_8213, 1'b0, 1'b0, 1'b0, acc);
      check("full_no_accept", {31'd0, acc}, 32'd0);
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) step(1'b1, 32'h0031_8213, 1'b1, 1'b0, 1'b0, acc);
      check("third_accepted", {31'd0, acc}, 32'd1);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

      step(1'b1, 32'h0040_0293, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0050_0313, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0060_0393, 1'b0, 1'b1, 1'b0, acc);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
`ifdef RV32I_DECODE_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, acc);
         check("trap_halt", {31'd0, in_ready}, 32'd0);
      end
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
      check("trap_release", {31'd0, in_ready}, 32'd1);
`endif

      step(1'b1, 32'h0070_0413, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h0080_0493, 1'b0, 1'b0, 1'b1, acc);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_imm", out_imm, 32'd0);
      check("midrst_out_type", {29'd0, out_type}, {29'd0, X_TYPE});

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0, acc);

      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
      check("drain_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
